// File: rtl/match_sequencer_pkg.sv
// Shared encodings and defaults for the match sequencer: game states, winner codes, widths.
package match_sequencer_pkg;

  localparam int unsigned SCORE_W          = 4;
  localparam int unsigned PAUSE_W          = 8;
  localparam int unsigned DEF_WIN_SCORE    = 9;
  localparam int unsigned DEF_PAUSE_FRAMES = 30;

  typedef enum logic [1:0] {
    P1_SERVE = 2'd0,
    P2_SERVE = 2'd1,
    PLAYING  = 2'd2,
    DONE     = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_TIE  = 2'd3
  } winner_t;

  // Winner by score comparison, used when the match timer runs out.
  function automatic winner_t winner_of(input logic [SCORE_W-1:0] s1,
                                        input logic [SCORE_W-1:0] s2);
    if (s1 > s2)      return WIN_P1;
    else if (s2 > s1) return WIN_P2;
    else              return WIN_TIE;
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Frame-sampled rising-edge detector for one button; the first frame after reset only primes history.
module frame_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic btn,
  output logic rise_c
);

  logic hist_q;
  logic primed_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q   <= 1'b0;
      primed_q <= 1'b0;
    end else if (frame_tick) begin
      hist_q   <= btn;
      primed_q <= 1'b1;
    end
  end

  assign rise_c = frame_tick & primed_q & btn & ~hist_q;

endmodule

// File: rtl/match_sequencer.sv
// Two-player match sequencer: serve lock-out, scoring, win/timeout resolution and restart.
module match_sequencer
  import match_sequencer_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
  parameter int unsigned PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               p1_serve_btn,
  input  logic               p2_serve_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  input  logic               time_up,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               ball_launch,
  output logic               point_pulse,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [PAUSE_W-1:0] PAUSE_VAL = PAUSE_W'(PAUSE_FRAMES);

  game_state_t        state_q;
  winner_t            winner_q;
  logic [SCORE_W-1:0] p1_q, p2_q;
  logic [PAUSE_W-1:0] pause_q;
  logic               launch_q, point_q;

  logic               p1_rise_c, p2_rise_c;
  logic               point_c, serve_press_c, restart_c;
  logic [SCORE_W-1:0] p1_next_c, p2_next_c;

  frame_edge_detect u_p1_edge (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn        (p1_serve_btn),
    .rise_c     (p1_rise_c)
  );

  frame_edge_detect u_p2_edge (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn        (p2_serve_btn),
    .rise_c     (p2_rise_c)
  );

  // Post-point scores; a double miss cancels out and scores nothing.
  always_comb begin
    p1_next_c     = p1_q;
    p2_next_c     = p2_q;
    point_c       = (state_q == PLAYING) && (miss_left ^ miss_right);
    serve_press_c = 1'b0;
    restart_c     = (p1_rise_c & p2_serve_btn) | (p2_rise_c & p1_serve_btn);
    if (point_c && miss_right) p1_next_c = p1_q + SCORE_W'(1);
    if (point_c && miss_left)  p2_next_c = p2_q + SCORE_W'(1);
    if (state_q == P1_SERVE)      serve_press_c = p1_rise_c;
    else if (state_q == P2_SERVE) serve_press_c = p2_rise_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= P1_SERVE;
      winner_q <= WIN_NONE;
      p1_q     <= '0;
      p2_q     <= '0;
      pause_q  <= '0;
      launch_q <= 1'b0;
      point_q  <= 1'b0;
    end else begin
      launch_q <= 1'b0;
      point_q  <= 1'b0;
      case (state_q)
        P1_SERVE, P2_SERVE: begin
          if (frame_tick && pause_q != '0) pause_q <= pause_q - PAUSE_W'(1);
          if (time_up) begin
            state_q  <= DONE;
            winner_q <= winner_of(p1_q, p2_q);
          end else if (pause_q == '0 && serve_press_c) begin
            launch_q <= 1'b1;
            state_q  <= PLAYING;
          end
        end
        PLAYING: begin
          if (point_c) begin
            p1_q    <= p1_next_c;
            p2_q    <= p2_next_c;
            point_q <= 1'b1;
          end
          if (point_c && p1_next_c == WIN_VAL) begin
            state_q  <= DONE;
            winner_q <= WIN_P1;
          end else if (point_c && p2_next_c == WIN_VAL) begin
            state_q  <= DONE;
            winner_q <= WIN_P2;
          end else if (time_up) begin
            state_q  <= DONE;
            winner_q <= winner_of(p1_next_c, p2_next_c);
          end else if (point_c) begin
            // Loser of the point serves next.
            state_q <= miss_left ? P1_SERVE : P2_SERVE;
            pause_q <= PAUSE_VAL;
          end
        end
        DONE: begin
          if (restart_c) begin
            state_q  <= P1_SERVE;
            winner_q <= WIN_NONE;
            p1_q     <= '0;
            p2_q     <= '0;
            pause_q  <= '0;
          end
        end
        default: state_q <= P1_SERVE;
      endcase
    end
  end

  assign game_state  = state_q;
  assign winner      = winner_q;
  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign ball_launch = launch_q;
  assign point_pulse = point_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: vector table plus hand-written serve/pause/win/reset sequences.
module tb_match_sequencer;

  logic       clk;
  logic       reset;
  logic       frame_tick, p1_serve_btn, p2_serve_btn, miss_left, miss_right, time_up;
  logic [1:0] game_state, winner;
  logic [3:0] p1_score, p2_score;
  logic       ball_launch, point_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  match_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .p1_serve_btn (p1_serve_btn),
    .p2_serve_btn (p2_serve_btn),
    .miss_left    (miss_left),
    .miss_right   (miss_right),
    .time_up      (time_up),
    .game_state   (game_state),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .ball_launch  (ball_launch),
    .point_pulse  (point_pulse),
    .winner       (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ft, b1, b2, ml, mr, tu;
    logic [1:0] st;
    logic [3:0] p1, p2;
    logic       bl, pp;
    logic [1:0] win;
  } vec_t;

  function automatic vec_t mk(input string name,
                              input logic ft, input logic b1, input logic b2,
                              input logic ml, input logic mr, input logic tu,
                              input logic [1:0] st, input logic [3:0] p1, input logic [3:0] p2,
                              input logic bl, input logic pp, input logic [1:0] win);
    vec_t v;
    v.name = name; v.ft = ft; v.b1 = b1; v.b2 = b2; v.ml = ml; v.mr = mr; v.tu = tu;
    v.st = st; v.p1 = p1; v.p2 = p2; v.bl = bl; v.pp = pp; v.win = win;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [3:0] p1,
                           input logic [3:0] p2, input logic bl, input logic pp,
                           input logic [1:0] win);
    check({tag, ".state"},  8'(game_state),  8'(st));
    check({tag, ".p1"},     8'(p1_score),    8'(p1));
    check({tag, ".p2"},     8'(p2_score),    8'(p2));
    check({tag, ".launch"}, 8'(ball_launch), 8'(bl));
    check({tag, ".point"},  8'(point_pulse), 8'(pp));
    check({tag, ".winner"}, 8'(winner),      8'(win));
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic ft, input logic b1, input logic b2,
                      input logic ml, input logic mr, input logic tu);
    frame_tick = ft; p1_serve_btn = b1; p2_serve_btn = b2;
    miss_left = ml; miss_right = mr; time_up = tu;
    @(posedge clk);
    #1;
    frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0; time_up = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // P1 wins a rally, sits out the pause, then P2 serves.
  task automatic score_p1();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(30);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("p2_serve.launch", 8'(ball_launch), 8'd1);
    check("p2_serve.state",  8'(game_state),  8'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic score_p2();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(30);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("p1_serve.launch", 8'(ball_launch), 8'd1);
    check("p1_serve.state",  8'(game_state),  8'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic restart_and_serve();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("restart", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("serve_after_restart.launch", 8'(ball_launch), 8'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = mk("prime_frame",  1, 0, 0, 0, 0, 0, 2'd0, 4'd0, 4'd0, 0, 0, 2'd0);
    vecs[1] = mk("p1_press",     1, 1, 0, 0, 0, 0, 2'd2, 4'd0, 4'd0, 1, 0, 2'd0);
    vecs[2] = mk("launch_clear", 1, 0, 0, 0, 0, 0, 2'd2, 4'd0, 4'd0, 0, 0, 2'd0);
    vecs[3] = mk("double_miss",  0, 0, 0, 1, 1, 0, 2'd2, 4'd0, 4'd0, 0, 0, 2'd0);
    vecs[4] = mk("miss_right",   0, 0, 0, 0, 1, 0, 2'd1, 4'd1, 4'd0, 0, 1, 2'd0);
    vecs[5] = mk("point_clear",  0, 0, 0, 0, 0, 0, 2'd1, 4'd1, 4'd0, 0, 0, 2'd0);

    reset = 1'b0;
    frame_tick = 1'b0; p1_serve_btn = 1'b0; p2_serve_btn = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0; time_up = 1'b0;
    @(posedge clk); #1;
    check_all("reset", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      step(vecs[i].ft, vecs[i].b1, vecs[i].b2, vecs[i].ml, vecs[i].mr, vecs[i].tu);
      check_all(vecs[i].name, vecs[i].st, vecs[i].p1, vecs[i].p2, vecs[i].bl, vecs[i].pp, vecs[i].win);
    end

    // Serve lock-out: 30 frames must elapse before P2 may serve; P1 is ignored.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("early_press", 2'd1, 4'd1, 4'd0, 1'b0, 1'b0, 2'd0);
    ticks(28);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("press_at_pause1", 2'd1, 4'd1, 4'd0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("non_server_press", 2'd1, 4'd1, 4'd0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("late_press", 2'd2, 4'd1, 4'd0, 1'b1, 1'b0, 2'd0);

    // P1 runs to WIN_SCORE; DONE then ignores misses and timeout.
    for (int i = 0; i < 7; i++) score_p1();
    check_all("p1_at_8", 2'd2, 4'd8, 4'd0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("p1_wins", 2'd3, 4'd9, 4'd0, 1'b0, 1'b1, 2'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_all("done_miss_left", 2'd3, 4'd9, 4'd0, 1'b0, 1'b0, 2'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("done_miss_right", 2'd3, 4'd9, 4'd0, 1'b0, 1'b0, 2'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    check_all("done_time_up", 2'd3, 4'd9, 4'd0, 1'b0, 1'b0, 2'd1);

    // 3/3 then timeout coincident with a P2 point.
    restart_and_serve();
    for (int i = 0; i < 3; i++) begin score_p1(); score_p2(); end
    check_all("tied_3_3", 2'd2, 4'd3, 4'd3, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_all("timeup_with_point", 2'd3, 4'd3, 4'd4, 1'b0, 1'b1, 2'd2);

    // 3/3 then timeout alone gives a tie.
    restart_and_serve();
    for (int i = 0; i < 3; i++) begin score_p1(); score_p2(); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("timeup_tie", 2'd3, 4'd3, 4'd3, 1'b0, 1'b0, 2'd3);

    // Asynchronous reset mid-pause, with P1 holding the button through it.
    restart_and_serve();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("pre_reset_point", 2'd1, 4'd1, 4'd0, 1'b0, 1'b1, 2'd0);
    ticks(5);
    p1_serve_btn = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("held_through_reset", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("serve_no_pause_after_reset", 2'd2, 4'd0, 4'd0, 1'b1, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 9, meaning score value that ends the match (range 1..15).
REQ-002 SHALL have parameter PAUSE_FRAMES, default 30, meaning frames of serve lock-out after each point (range 1..255).
REQ-003 SHALL have port clk  input  1  single system clock, all flops on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port frame_tick  input  1  one-clk pulse per video frame (60 Hz).
REQ-006 SHALL have ports p1_serve_btn, p2_serve_btn  input  1 each  active-high button levels.
REQ-007 SHALL have ports miss_left, miss_right  input  1 each  one-clk pulses: ball exited left (P2 point) / right (P1 point).
REQ-008 SHALL have port time_up  input  1  level, match timer expired.
REQ-009 SHALL have port game_state  output  2  0=P1_SERVE, 1=P2_SERVE, 2=PLAYING, 3=DONE.
REQ-010 SHALL have ports p1_score, p2_score  output  4 each  current scores.
REQ-011 SHALL have port ball_launch  output  1  one-clk pulse when a serve is accepted.
REQ-012 SHALL have port point_pulse  output  1  one-clk pulse when a point is scored.
REQ-013 SHALL have port winner  output  2  0=none, 1=P1, 2=P2, 3=tie; valid in DONE.

Function
REQ-014 Buttons SHALL be sampled only on frame_tick; a press is a sample of 1 when the previous frame_tick sample was 0.
REQ-015 In P1_SERVE/P2_SERVE, the internal pause counter SHALL decrement by 1 per frame_tick while nonzero, with no wrap below 0.
REQ-016 In PxX_SERVE with the pause counter at 0, a press of the serving player's button SHALL pulse ball_launch for that clk and set game_state=PLAYING on the next clk.
REQ-017 The non-serving player's button SHALL be ignored in serve states.
REQ-018 In PLAYING, miss_left alone SHALL increment p2_score, pulse point_pulse, and give next state P1_SERVE (loser serves).
REQ-019 In PLAYING, miss_right alone SHALL increment p1_score, pulse point_pulse, and give next state P2_SERVE.
REQ-020 In PLAYING, simultaneous miss_left and miss_right SHALL be ignored: no score change, state stays PLAYING.
REQ-021 miss_left/miss_right outside PLAYING SHALL be ignored.
REQ-022 Each point not ending the match SHALL load the pause counter with PAUSE_FRAMES.
REQ-023 A point that makes a score equal WIN_SCORE SHALL give next state DONE and set winner to that player; scores never exceed WIN_SCORE.
REQ-024 time_up high in any non-DONE state SHALL give next state DONE, with winner set by the higher score, or 3 on equal scores.
REQ-025 time_up coincident with a miss SHALL count the point first; winner SHALL be computed from post-point scores.
REQ-026 In DONE, scores and winner SHALL hold until a frame_tick on which both buttons are sampled high while at least one was low on the previous sample.
REQ-027 That DONE restart SHALL clear scores, winner, and pause counter, and set P1_SERVE.
REQ-028 ball_launch and point_pulse SHALL never be high in the same clk.
REQ-029 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-030 While reset=0: game_state=P1_SERVE, scores=0, winner=0, ball_launch=0, point_pulse=0, pause counter=0, button history=0.
REQ-031 Reset assertion mid-rally or mid-pause SHALL abort immediately, asynchronously.
REQ-032 The first frame_tick after reset release SHALL only load button history; a button held through reset does not serve.

Structure
REQ-033 The shared game package SHALL hold the game_state encodings (P1_SERVE, P2_SERVE, PLAYING, DONE), the winner encodings, and the default WIN_SCORE and PAUSE_FRAMES.
REQ-034 A single sub-module, frame_edge_detect, SHALL implement per-button frame-sampled rising-edge detection, instantiated once per button.

Verification
REQ-035 Bench: reset, then p1 press on frame 2 -> ball_launch one clk, game_state 0->2.
REQ-036 Bench: PLAYING, miss_right -> p1_score 1, point_pulse, state 1; p2 press before 30 frame_ticks -> ignored; press after -> launch.
REQ-037 Bench: p1_score=8, miss_right -> p1_score 9, state 3, winner 1; further misses and time_up -> no change.
REQ-038 Bench: scores 3/3, time_up plus miss_left same clk -> p2_score 4, state 3, winner 2; separately 3/3 with time_up alone -> winner 3.
REQ-039 Bench: simultaneous miss_left and miss_right -> scores unchanged, state 2, no point_pulse.
REQ-040 Bench: DONE, both buttons pressed -> scores 0, winner 0, state 0; reset pulse mid-pause -> all reset values within the reset clk.
